// File: rtl/seg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : seg_pkg                                                         |
// | Purpose  : Glyph constants and hex-to-segment decoding shared by the       |
// |            7-segment scan driver. All patterns are active-low,             |
// |            bit order {dp,g,f,e,d,c,b,a}; the constants carry dp off (1).   |
// | Contents : seg_t, SEG_0..SEG_F, SEG_E/SEG_R/SEG_O, SEG_OFF, hex_to_seg()   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package seg_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_0   = 8'hC0;
  localparam seg_t SEG_1   = 8'hF9;
  localparam seg_t SEG_2   = 8'hA4;
  localparam seg_t SEG_3   = 8'hB0;
  localparam seg_t SEG_4   = 8'h99;
  localparam seg_t SEG_5   = 8'h92;
  localparam seg_t SEG_6   = 8'h82;
  localparam seg_t SEG_7   = 8'hF8;
  localparam seg_t SEG_8   = 8'h80;
  localparam seg_t SEG_9   = 8'h90;
  localparam seg_t SEG_A   = 8'h88;
  localparam seg_t SEG_B   = 8'h83;
  localparam seg_t SEG_C   = 8'hC6;
  localparam seg_t SEG_D   = 8'hA1;
  localparam seg_t SEG_E   = 8'h86;
  localparam seg_t SEG_F   = 8'h8E;
  localparam seg_t SEG_R   = 8'hAF;
  localparam seg_t SEG_O   = 8'hA3;
  localparam seg_t SEG_OFF = 8'hFF;

  // Returns only the seven segment bits; the caller merges its own dp bit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    seg_t g;
    case (nibble)
      4'h0:    g = SEG_0;
      4'h1:    g = SEG_1;
      4'h2:    g = SEG_2;
      4'h3:    g = SEG_3;
      4'h4:    g = SEG_4;
      4'h5:    g = SEG_5;
      4'h6:    g = SEG_6;
      4'h7:    g = SEG_7;
      4'h8:    g = SEG_8;
      4'h9:    g = SEG_9;
      4'hA:    g = SEG_A;
      4'hB:    g = SEG_B;
      4'hC:    g = SEG_C;
      4'hD:    g = SEG_D;
      4'hE:    g = SEG_E;
      default: g = SEG_F;
    endcase
    return g[6:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: seg_scan_driver_if                                              |
// | Purpose  : Bundles the display data coming from the formatting logic and   |
// |            the pin-level outputs of the scan driver.                       |
// | Signals  : numb[4*DIGITS], dp[DIGITS], mask[DIGITS], error, brightness     |
// |            (formatter -> driver); anodes[DIGITS], cathodes[8], frame_done  |
// |            (driver -> pins / formatter).                                   |
// | Modports : master = formatter side, slave = scan driver side               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface seg_scan_driver_if #(
  parameter int DIGITS = 8,
  parameter int DUTY_W = 4
);
  logic [4*DIGITS-1:0] numb;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   mask;
  logic                error;
  logic [DUTY_W-1:0]   brightness;
  logic [DIGITS-1:0]   anodes;
  logic [7:0]          cathodes;
  logic                frame_done;

  modport master (
    output numb, dp, mask, error, brightness,
    input  anodes, cathodes, frame_done
  );

  modport slave (
    input  numb, dp, mask, error, brightness,
    output anodes, cathodes, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/seg_glyph_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg_glyph_sel                                                   |
// | Purpose  : Combinational cathode pattern for the digit being scanned.      |
// |            Normal mode decodes the shadow nibble and merges the dp bit;    |
// |            error mode spells "Error" on digits 4..0 (dp off).              |
// | Ports    : idx   in  IDX_W      digit currently scanned                    |
// |            numb  in  4*DIGITS   shadow nibbles                             |
// |            dp    in  DIGITS     shadow decimal points (1 = lit)            |
// |            error in  1          shadow error flag                          |
// |            seg   out 8          active-low {dp,g,f,e,d,c,b,a}              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seg_glyph_sel
  import seg_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int IDX_W  = 3
) (
  input  logic [IDX_W-1:0]    idx,
  input  logic [4*DIGITS-1:0] numb,
  input  logic [DIGITS-1:0]   dp,
  input  logic                error,
  output seg_t                seg
);

  always_comb begin
    seg = SEG_OFF;
    if (error) begin
      // Digit 4 is the leftmost letter; narrower displays keep the tail.
      case (32'(idx))
        0:       seg = SEG_R;
        1:       seg = SEG_O;
        2:       seg = SEG_R;
        3:       seg = SEG_R;
        4:       seg = SEG_E;
        default: seg = SEG_OFF;
      endcase
    end else begin
      seg = {~dp[idx], hex_to_seg(numb[{idx, 2'b00} +: 4])};
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg_scan_driver                                                 |
// | Purpose  : Time-multiplexed driver for a DIGITS-wide common-anode          |
// |            7-segment display with anti-ghost blanking, per-frame shadow    |
// |            capture (no tearing) and an "Error" display mode.               |
// | Ports    : clk  in   system clock                                          |
// |            rst  in   asynchronous reset, active-high                       |
// |            bus  slave modport of seg_scan_driver_if (numb, dp, mask,       |
// |                 error, brightness in; anodes, cathodes, frame_done out)    |
// | Options  : SEG_DIMMING_EN - enables PWM brightness on the anode window.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int SLOT_CYCLES  = 1024,
  parameter int BLANK_CYCLES = 4,
  parameter int DUTY_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  seg_scan_driver_if.slave bus
);

  localparam int SLOT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [SLOT_W-1:0] c_slot_last = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] c_blank     = SLOT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  c_idx_last  = IDX_W'(DIGITS - 1);

  logic [SLOT_W-1:0]   r_slot;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_numb;
  logic [DIGITS-1:0]   r_dp;
  logic [DIGITS-1:0]   r_mask;
  logic                r_err;
  logic [DIGITS-1:0]   r_anodes;
  seg_t                r_cathodes;
  logic                r_frame_done;

  logic                w_slot_wrap;
  logic                w_boundary;
  logic                w_window;
  logic                w_digit_ok;
  logic                w_anode_on;
  logic [DIGITS-1:0]   w_anodes_nxt;
  seg_t                w_glyph;

  assign w_slot_wrap = (r_slot == c_slot_last);
  assign w_boundary  = w_slot_wrap && (r_idx == c_idx_last);

`ifdef SEG_DIMMING_EN
  logic [DUTY_W-1:0] r_bright;

  // Phase only matters once blanking is over, so the subtraction never
  // underflows where the result is used.
  assign w_window = (DUTY_W'(r_slot - c_blank) <= r_bright);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bright <= '0;
    end else if (w_boundary) begin
      r_bright <= bus.brightness;
    end
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^bus.brightness;
  assign w_window          = 1'b1;
`endif

  // Error mode overrides the mask and only lights the five text positions.
  assign w_digit_ok   = r_err ? (32'(r_idx) < 32'd5) : ~r_mask[r_idx];
  assign w_anode_on   = (r_slot >= c_blank) && w_digit_ok && w_window;
  assign w_anodes_nxt = w_anode_on ? ~(DIGITS'(1) << r_idx) : '1;

  seg_glyph_sel #(
    .DIGITS (DIGITS),
    .IDX_W  (IDX_W)
  ) u_glyph_sel (
    .idx   (r_idx),
    .numb  (r_numb),
    .dp    (r_dp),
    .error (r_err),
    .seg   (w_glyph)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot       <= '0;
      r_idx        <= '0;
      r_numb       <= '0;
      r_dp         <= '0;
      r_mask       <= '1;   // first frame after reset stays dark
      r_err        <= 1'b0;
      r_anodes     <= '1;
      r_cathodes   <= SEG_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_slot <= w_slot_wrap ? '0 : r_slot + SLOT_W'(1);
      if (w_slot_wrap) begin
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + IDX_W'(1);
      end
      // Shadow copy only at the frame boundary so a frame never mixes data.
      if (w_boundary) begin
        r_numb <= bus.numb;
        r_dp   <= bus.dp;
        r_mask <= bus.mask;
        r_err  <= bus.error;
      end
      r_anodes     <= w_anodes_nxt;
      r_cathodes   <= w_glyph;
      r_frame_done <= w_boundary;
    end
  end

  assign bus.anodes     = r_anodes;
  assign bus.cathodes   = r_cathodes;
  assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire
